// File: rtl/turing_machine_if.sv
// rtl/turing_machine_if.sv - front-panel and debug signal bundle for the Turing machine
// Purpose: groups the user buttons/program word (driven by the board or bench)
//          and the debug/display outputs (driven by the machine).
// Ports (master = panel side, slave = machine side):
//   input_data, Next, Done           panel -> machine
//   Compute_done, display_out,
//   currState, display_in,
//   tape_reg_out, data_reg_out,
//   next_state_out, tape_addr_out    machine -> panel
interface turing_machine_if #(
  parameter int STATE_W = 4,
  parameter int AW      = 6
);
  logic [STATE_W-1:0]      input_data;
  logic                    Next;
  logic                    Done;
  logic                    Compute_done;
  logic [AW+STATE_W:0]     display_out;
  logic [STATE_W-1:0]      currState;
  logic                    display_in;
  logic                    tape_reg_out;
  logic                    data_reg_out;
  logic [AW-1:0]           next_state_out;
  logic [AW-1:0]           tape_addr_out;

  modport master (
    output input_data, Next, Done,
    input  Compute_done, display_out, currState, display_in,
           tape_reg_out, data_reg_out, next_state_out, tape_addr_out
  );

  modport slave (
    input  input_data, Next, Done,
    output Compute_done, display_out, currState, display_in,
           tape_reg_out, data_reg_out, next_state_out, tape_addr_out
  );
endinterface

// File: rtl/turing_machine.sv
// rtl/turing_machine.sv - programmable single-tape binary Turing machine
// Purpose: rule table is entered one word per Next press, closed with Done,
//          then each Next press performs one machine step (rule search + apply).
// Ports:
//   clock          single clock, posedge
//   reset          synchronous, active-high; clears program, tape and all state
//   bus (slave)    input_data/Next/Done buttons in; Compute_done, display_out,
//                  currState, display_in, tape_reg_out, data_reg_out,
//                  next_state_out, tape_addr_out out
module turing_machine #(
  parameter int STATE_W  = 4,
  parameter int TAPE_LEN = 64
) (
  input  logic              clock,
  input  logic              reset,
  turing_machine_if.slave   bus
);
  localparam int AW = $clog2(TAPE_LEN);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_SEARCH, S_HALT} state_t;

  state_t               state, state_nxt;
  logic                 next_q, done_q;
  logic [AW:0]          wcount;      // one extra bit so it can reach TAPE_LEN
  logic [AW-2:0]        idx;         // rule index, 0..TAPE_LEN/4
  logic [AW-1:0]        head;
  logic [STATE_W-1:0]   cur_state;
  logic [TAPE_LEN-1:0]  tape;
  logic                 data_reg;
  logic [STATE_W-1:0]   prog [TAPE_LEN];

  logic                 press_next, press_done;
  logic [AW-2:0]        rule_count;
  logic [AW-1:0]        rule_base;
  logic [STATE_W-1:0]   w0, w2, w3;
  logic                 w1_sym;
  logic                 search_end, rule_hit;

  assign press_next = bus.Next & ~next_q;
  assign press_done = bus.Done & ~done_q;

  // Trailing partial rule is dropped by the divide-by-4.
  assign rule_count = wcount[AW:2];
  // idx only addresses memory while idx < rule_count, so its low bits suffice.
  assign rule_base  = {idx[AW-3:0], 2'b00};
  assign w0         = prog[rule_base];
  assign w1_sym     = prog[rule_base | AW'(1)][0];
  assign w2         = prog[rule_base | AW'(2)];
  assign w3         = prog[rule_base | AW'(3)];

  assign search_end = (idx == rule_count);
  assign rule_hit   = (w0 == cur_state) && (w1_sym == tape[head]);

  always_ff @(posedge clock) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (press_done) state_nxt = S_IDLE;
      S_IDLE:   if (press_next) state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (search_end)    state_nxt = S_HALT;
        else if (rule_hit) state_nxt = w2[2] ? S_HALT : S_IDLE;
      end
      default:  state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      next_q    <= 1'b0;
      done_q    <= 1'b0;
      wcount    <= '0;
      idx       <= '0;
      head      <= '0;
      cur_state <= '0;
      tape      <= '0;
      data_reg  <= 1'b0;
      for (int i = 0; i < TAPE_LEN; i++) prog[i] <= '0;
    end else begin
      next_q <= bus.Next;
      done_q <= bus.Done;
      case (state)
        S_LOAD: begin
          // A word arriving together with Done is still stored.
          if (press_next && !wcount[AW]) begin
            prog[wcount[AW-1:0]] <= bus.input_data;
            wcount               <= wcount + 1'b1;
          end
        end
        S_IDLE: begin
          if (press_next) idx <= '0;
        end
        S_SEARCH: begin
          if (!search_end) begin
            if (rule_hit) begin
              // idx is left on the applied rule so next_state_out points at it.
              tape[head] <= w2[0];
              data_reg   <= w2[0];
              head       <= w2[1] ? head - 1'b1 : head + 1'b1;
              cur_state  <= w3;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Compute_done   = (state == S_HALT);
  assign bus.display_in     = (state == S_LOAD);
  assign bus.currState      = cur_state;
  assign bus.tape_reg_out   = tape[head];
  assign bus.data_reg_out   = data_reg;
  assign bus.next_state_out = rule_base;
  assign bus.tape_addr_out  = head;
  assign bus.display_out    = (state == S_LOAD) ? {1'b0, wcount[AW-1:0], bus.input_data}
                                                : {1'b1, head, cur_state};
endmodule

// File: tb/tb_turing_machine.sv
// tb/tb_turing_machine.sv - randomized self-checking bench for turing_machine
module tb_turing_machine;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  turing_machine_if bus ();
  turing_machine dut (.clock(clock), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model: program as a word array, tape as a bit array.
  logic [3:0] m_prog [64];
  int         m_wcount, m_head, m_state, m_ns;
  bit         m_tape [64];
  bit         m_data, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_prog[i] = 4'd0;
      m_tape[i] = 1'b0;
    end
    m_wcount = 0; m_head = 0; m_state = 0; m_ns = 0;
    m_data = 1'b0; m_halted = 1'b0;
  endtask

  task automatic do_reset();
    bus.Next = 1'b0;
    bus.Done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic enter_word(input logic [3:0] w, input int hold, input bit with_done);
    logic [10:0] exp_disp;
    bus.input_data = w;
    bus.Next = 1'b1;
    bus.Done = with_done;
    tick();
    if (m_wcount < 64) m_prog[m_wcount] = w;
    if (m_wcount < 64) m_wcount++;
    bus.Done = 1'b0;
    repeat (hold - 1) tick();
    bus.Next = 1'b0;
    tick();
    if (with_done) begin
      check("load_exit", bus.display_in, 0);
    end else begin
      exp_disp = {1'b0, 6'(m_wcount % 64), w};
      check("load_disp", bus.display_out, exp_disp);
    end
  endtask

  task automatic finish_load();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    tick();
    check("idle_mode", bus.display_in, 0);
  endtask

  task automatic check_all();
    logic [10:0] exp_disp;
    exp_disp = {1'b1, 6'(m_head), 4'(m_state)};
    check("head",  bus.tape_addr_out,  m_head);
    check("state", bus.currState,      m_state);
    check("tape",  bus.tape_reg_out,   m_tape[m_head]);
    check("data",  bus.data_reg_out,   m_data);
    check("done",  bus.Compute_done,   m_halted);
    check("ns",    bus.next_state_out, m_ns);
    check("disp",  bus.display_out,    exp_disp);
  endtask

  // One Next press in IDLE/HALT; checks latency and the resulting machine state.
  task automatic do_step();
    int rules, hit, old_head;
    logic [3:0] w2;
    rules = m_wcount / 4;
    hit = -1;
    old_head = m_head;
    if (m_halted) begin
      bus.Next = 1'b1;
      tick();
      bus.Next = 1'b0;
      repeat (3) tick();
      check_all();
      return;
    end
    for (int r = 0; r < rules; r++) begin
      if (hit < 0 && m_prog[4*r] == 4'(m_state) && m_prog[4*r+1][0] == m_tape[m_head])
        hit = r;
    end
    bus.Next = 1'b1;
    tick();
    bus.Next = 1'b0;
    if (hit >= 0) begin
      repeat (hit) tick();
      check("early_head", bus.tape_addr_out, old_head);
      tick();
      w2 = m_prog[4*hit+2];
      m_tape[m_head] = w2[0];
      m_data = w2[0];
      m_head = w2[1] ? (m_head + 63) % 64 : (m_head + 1) % 64;
      m_state = m_prog[4*hit+3];
      m_ns = (4 * hit) % 64;
      if (w2[2]) m_halted = 1'b1;
    end else begin
      repeat (rules) tick();
      check("early_done", bus.Compute_done, 0);
      tick();
      m_halted = 1'b1;
      m_ns = (4 * rules) % 64;
    end
    check_all();
  endtask

  task automatic enter_rule(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    enter_word(a, 1, 0);
    enter_word(b, 1, 0);
    enter_word(c, 1, 0);
    enter_word(d, 1, 0);
  endtask

  initial begin
    logic [3:0] w;
    int nr, nw;
    bit cd;

    bus.input_data = 4'($urandom);
    bus.Next = 1'b0;
    bus.Done = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();

    // reset values
    check("rst_done",  bus.Compute_done, 0);
    check("rst_mode",  bus.display_in, 1);
    check("rst_state", bus.currState, 0);
    check("rst_head",  bus.tape_addr_out, 0);
    check("rst_tape",  bus.tape_reg_out, 0);
    check("rst_data",  bus.data_reg_out, 0);
    check("rst_ns",    bus.next_state_out, 0);
    check("rst_disp",  bus.display_out, {1'b0, 6'd0, bus.input_data});

    // long press counts once
    enter_word(4'd3, 6, 0);
    check("hold_disp", bus.display_out, 11'h013);

    // left-walking writer
    do_reset();
    enter_rule(4'd0, 4'd0, 4'b0011, 4'd0);
    finish_load();
    repeat (3) do_step();
    check("walk_head", bus.tape_addr_out, 61);

    // first matching rule is rule 4
    do_reset();
    enter_rule(4'd3, 4'd1, 4'd0, 4'd2);
    enter_rule(4'd0, 4'd1, 4'd1, 4'd0);
    enter_rule(4'd1, 4'd1, 4'd1, 4'd1);
    enter_rule(4'd1, 4'd0, 4'd2, 4'd3);
    enter_rule(4'd0, 4'd2, 4'd3, 4'd0);
    enter_rule(4'd0, 4'd0, 4'd0, 4'd0);
    enter_rule(4'd0, 4'd0, 4'd0, 4'd1);
    finish_load();
    do_step();
    check("r4_ns",   bus.next_state_out, 16);
    check("r4_head", bus.tape_addr_out, 63);

    // halt-after-step rule, then presses are ignored
    do_reset();
    enter_rule(4'd0, 4'd0, 4'b0101, 4'd5);
    finish_load();
    do_step();
    check("halt_state", bus.currState, 5);
    check("halt_done",  bus.Compute_done, 1);
    do_step();
    do_step();

    // empty program halts one cycle after the press
    do_reset();
    finish_load();
    do_step();

    // saturating word count, last rule in the top words, reset mid-search
    do_reset();
    for (int r = 0; r < 15; r++) enter_rule(4'd15, 4'd0, 4'd0, 4'd0);
    enter_rule(4'd0, 4'd0, 4'b0001, 4'd9);
    enter_word(4'd6, 1, 0);
    finish_load();
    do_step();
    check("sat_state", bus.currState, 9);
    bus.Next = 1'b1;
    tick();
    bus.Next = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("abort_mode",  bus.display_in, 1);
    check("abort_head",  bus.tape_addr_out, 0);
    check("abort_tape",  bus.tape_reg_out, 0);
    check("abort_state", bus.currState, 0);
    finish_load();
    do_step();

    // random programs and runs
    for (int it = 0; it < 20; it++) begin
      do_reset();
      nr = $urandom_range(1, 10);
      nw = 4 * nr + $urandom_range(0, 3);
      cd = $urandom_range(0, 1);
      for (int i = 0; i < nw; i++) begin
        case (i % 4)
          0: w = 4'($urandom_range(0, 3));
          1: w = 4'($urandom);
          2: w = {1'($urandom), ($urandom_range(0, 5) == 0), 2'($urandom)};
          default: w = 4'($urandom_range(0, 3));
        endcase
        enter_word(w, $urandom_range(1, 3), cd && (i == nw - 1));
      end
      if (!cd) finish_load();
      for (int s = 0; s < 10; s++) do_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/turing_machine.md
# turing_machine

Programmable single-tape binary Turing machine for the board-level demo top. The user enters a rule table one 4-bit word at a time with a Next button, closes entry with Done, then single-steps the machine with Next. Tape contents, head position and state are exposed on debug outputs and packed into an 11-bit display word.

## Interface
- STATE_W, 4: state register width; also program word width.
- TAPE_LEN, 64: tape cells and program-memory words (power of two); AW = log2(TAPE_LEN) = 6.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock-sampled reset restores all state below.
- input_data  in  4  program word to be entered.
- Next  in  1  button, level; only its rising edge acts (press = Next & ~Next_q).
- Done  in  1  button, level; rising edge ends program entry.
- Compute_done  out  1  machine halted.
- display_out  out  11  {mode, AW-bit field, 4-bit field}; see Operation.
- currState  out  STATE_W  current machine state.
- display_in  out  1  1 while in LOAD mode.
- tape_reg_out  out  1  tape[head].
- data_reg_out  out  1  symbol written by the most recent step.
- next_state_out  out  AW  program word address of the rule being examined/last applied.
- tape_addr_out  out  AW  head position.

## Operation
- FSM states: LOAD, IDLE, SEARCH, HALT. Reset -> LOAD; word count, rule index, head, state, tape (all 0), data_reg cleared; Next_q/Done_q cleared.
- LOAD: each Next press writes input_data to prog[wcount], wcount++. Once wcount = TAPE_LEN, further presses are ignored. Done press -> IDLE; rule_count = wcount/4 (trailing partial rule ignored). Next and Done pressed in the same cycle: the word is written, then the FSM goes to IDLE.
- Rule r occupies words 4r..4r+3: w0 = match state; w1[0] = match symbol (other bits ignored); w2[0] = write symbol, w2[1] = direction (0: head+1, 1: head-1), w2[2] = halt after step; w3 = next state.
- IDLE: a Next press -> SEARCH with idx = 0. Done is ignored outside LOAD.
- SEARCH, one rule per cycle:
  - If idx = rule_count -> HALT.
  - Else if w0 = currState and w1[0] = tape[head]: tape[head] <= w2[0], data_reg <= w2[0], head moves modulo TAPE_LEN (wrap 0<->63), currState <= w3, -> HALT if w2[2] else IDLE.
  - Else idx++.
  - First match wins. Next presses during SEARCH are ignored.
- HALT: Compute_done = 1; all inputs ignored until reset.
- display_out:
  - LOAD = {1'b0, wcount, input_data}.
  - Otherwise = {1'b1, head, currState}.
- next_state_out = 4*idx (word address of the current or last rule).

## Timing
- All outputs registered or decoded from registers; reset values: Compute_done 0, display_in 1, currState 0, tape_addr_out 0, tape_reg_out 0, data_reg_out 0, next_state_out 0, display_out = {0, 0, input_data}.
- Press at edge k (Next = 1 sampled at k, 0 at k-1): the LOAD write is visible after edge k; in IDLE, SEARCH is entered at edge k.
- Step latency: matching rule r is applied at edge k+1+r; no match is detected at edge k+1+rule_count.
- Holding Next for any number of cycles counts as one press.
- Reset mid-SEARCH or in HALT aborts immediately and erases program and tape.

## Test plan
- Reset, check all reset values; press Next with input_data = 3 held 6 cycles -> wcount = 1, prog[0] = 3, display_out = {0, 6'd1, 4'd3}.
- Enter rule (0, 0, 4'b0011, 0) then Done; 3 Next presses -> head 63, 62, 61; tape bits there = 1; currState 0; Compute_done 0.
- Enter the rules (3,1,0,2), (0,1,1,0), (1,1,1,1), (1,0,2,3), (0,2,3,0), (0,0,0,0), (0,0,0,1) then Done; first press matches rule 4 at edge k+5: head = 63, tape[0] = 1, next_state_out = 16.
- Rule (0, 0, 4'b0101, 5) -> one step: head 1, currState 5, Compute_done 1; further Next presses change nothing.
- Done with zero rules, then press Next -> HALT at edge k+1.
- Enter 65 words -> wcount saturates at 64 and prog[63] holds the 64th word; reset during SEARCH -> LOAD with a cleared tape.
